wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  Writeback stage downstream of the execute units (ALU rslt1, shifter rslt3).
//  Tracks the destination tag of every issued op across the units' 1-cycle
//  registered latency, pairs tag with result, and buffers pairs in a FIFO.
//  Drains to the register-file write port; load results take priority.
//  Exports a per-register pending bitmap for hazard detection upstream.
// PARAMETERS
//  XLEN   32  data width
//  RW     5   register address width
//  DEPTH  4   result FIFO entries; power of 2, >=2
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      async active-low reset
//  issue_valid  in   1      op issued to an execute unit this cycle
//  issue_sel    in   2      unit: 0=ALU, 1=SHIFT; 2,3 reserved
//  issue_rd     in   RW     destination register of issued op
//  rslt1        in   XLEN   ALU result, valid 1 cycle after issue
//  rslt3        in   XLEN   shifter result, valid 1 cycle after issue
//  lsu_valid    in   1      load result ready to write this cycle
//  lsu_rd       in   RW     load destination
//  lsu_data     in   XLEN   load data
//  rf_we        out  1      register-file write enable (registered)
//  rf_waddr     out  RW     write address (registered)
//  rf_wdata     out  XLEN   write data (registered)
//  busy         out  2**RW  bit r=1: a write to r is in tag reg or FIFO
//  stall        out  1      upstream must not issue
//  ovf_err      out  1      sticky: issue accepted while stall was high
// BEHAVIOUR
//  Reset: tag reg invalid, FIFO empty, rf_we/rf_waddr/rf_wdata/ovf_err = 0.
//  Reset mid-operation discards every in-flight tag and entry; no write emitted.
//  Edge E0: issue_valid=1 -> tag_q <= {1,sel,rd}; else tag_q.valid <= 0.
//  Edge E1: tag_q.valid and rd!=0 -> push {rd, sel?rslt3:rslt1}. rd==0 never pushed.
//   Reserved sel: treated as ALU.
//  Write port, evaluated each edge:
//   lsu_valid=1        -> rf <= {1,lsu_rd,lsu_data}; FIFO holds.
//   else FIFO nonempty -> pop head; rf <= {1,head.rd,head.data}.
//   else               -> rf_we <= 0; addr/data hold.
//  Latency, idle FIFO, no LSU: issue at E0 -> rf_we high after E2 for one cycle.
//  Push and pop on the same edge are both permitted; count unchanged.
//  Pop from an empty FIFO and bypass from tag reg to rf are not allowed.
//  stall = (count + tag_q.valid) >= DEPTH-1. Combinational.
//  issue_valid while stall=1: op dropped, ovf_err <= 1. Cleared only by reset.
//  busy: combinational OR of tag_q (valid, rd!=0) and each valid FIFO entry rd.
//   Duplicate rd entries are handled naturally; LSU writes are not tracked.
//  Same-rd collision (LSU now, FIFO head later): FIFO value is written last.
//  Write pointers wrap modulo DEPTH; count width is $clog2(DEPTH)+1.
// STRUCTURE
//  dlprv_pkg: XLEN, RW, UNIT_ALU=2'd0, UNIT_SHIFT=2'd1, wb_entry_t {rd,data}.
//  Sub-module wb_fifo: sync FIFO of wb_entry_t.
//   Exposes push/pop/count and per-entry rd+valid vectors for busy.
//  Top level contains: tag reg, result mux, write-port arbiter, stall/busy
//   logic, ovf_err flag.
// TESTING
//  1 SHIFT rd=5, rslt3=0x10 at E1 -> rf_we=1, waddr=5, wdata=0x10 after E2;
//    busy[5] high after E0, low after E2.
//  2 ALU rd=0, rslt1=0xFFFF -> no push, busy stays 0, rf_we stays 0.
//  3 ALU rd=3 (0xA) with lsu_valid rd=3 data=0xB held E2..E3 -> writes 0xB,
//    then 0xA after E4; FIFO empty after.
//  4 DEPTH=4, lsu_valid held, issue each cycle -> stall after 3 in flight;
//    4th issue under stall -> dropped, ovf_err=1; release LSU -> 3 writes in order.
//  5 Two SHIFTs to rd=7 (0x1, then 0x2) -> busy[7] until second write;
//    rf writes 0x1 then 0x2.
//  6 rst_n low with 2 FIFO entries + valid tag -> all outputs 0 immediately;
//    no writes after release.

Source files
------------

// File: rtl/dlprv_pkg.sv
// Shared widths, unit encodings and record types for the writeback stage.
package dlprv_pkg;

    localparam int XLEN = 32;
    localparam int RW   = 5;

    localparam logic [1:0] UNIT_ALU   = 2'd0;
    localparam logic [1:0] UNIT_SHIFT = 2'd1;

    typedef struct packed {
        logic [RW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    typedef struct packed {
        logic          valid;
        logic [1:0]    sel;
        logic [RW-1:0] rd;
    } wb_tag_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries; exposes per-slot rd/valid so the
// top level can build the pending-register bitmap.
module wb_fifo
    import dlprv_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  wb_entry_t                  push_entry,
    input  logic                       pop,
    output wb_entry_t                  head,
    output logic [CW-1:0]              count,
    output logic [DEPTH-1:0][RW-1:0]   entry_rd,
    output logic [DEPTH-1:0]           entry_valid
);

    wb_entry_t      mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           pop_ok;
    logic           push_ok;

    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && ((count != CW'(DEPTH)) || pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_entry;
    end

    // A slot is live when its distance from the read pointer is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [AW-1:0] offs;
        assign offs           = AW'(i) - rd_ptr;
        assign entry_valid[i] = ({1'b0, offs} < count);
        assign entry_rd[i]    = mem[i].rd;
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: pairs issued tags with execute results, buffers them and
// drains to the register-file write port with load results taking priority.
module wb_stage
    import dlprv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               issue_valid,
    input  logic [1:0]         issue_sel,
    input  logic [RW-1:0]      issue_rd,
    input  logic [XLEN-1:0]    rslt1,
    input  logic [XLEN-1:0]    rslt3,
    input  logic               lsu_valid,
    input  logic [RW-1:0]      lsu_rd,
    input  logic [XLEN-1:0]    lsu_data,
    output logic               rf_we,
    output logic [RW-1:0]      rf_waddr,
    output logic [XLEN-1:0]    rf_wdata,
    output logic [2**RW-1:0]   busy,
    output logic               stall,
    output logic               ovf_err
);

    localparam int CW = $clog2(DEPTH) + 1;

    wb_tag_t                  tag_q;
    wb_entry_t                push_entry;
    wb_entry_t                head;
    logic                     push;
    logic                     pop;
    logic [CW-1:0]            count;
    logic [DEPTH-1:0][RW-1:0] entry_rd;
    logic [DEPTH-1:0]         entry_valid;
    logic [CW:0]              in_flight;

    assign in_flight = {1'b0, count} + (CW+1)'(tag_q.valid);
    assign stall     = (in_flight >= (CW+1)'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q   <= '0;
            ovf_err <= 1'b0;
        end else begin
            tag_q.valid <= issue_valid && !stall;
            tag_q.sel   <= issue_sel;
            tag_q.rd    <= issue_rd;
            if (issue_valid && stall) ovf_err <= 1'b1;
        end
    end

    // Reserved unit encodings fall back to the ALU result.
    assign push            = tag_q.valid && (tag_q.rd != '0);
    assign push_entry.rd   = tag_q.rd;
    assign push_entry.data = (tag_q.sel == UNIT_SHIFT) ? rslt3 : rslt1;
    assign pop             = !lsu_valid;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .head        (head),
        .count       (count),
        .entry_rd    (entry_rd),
        .entry_valid (entry_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (lsu_valid) begin
            rf_we    <= 1'b1;
            rf_waddr <= lsu_rd;
            rf_wdata <= lsu_data;
        end else if (count != '0) begin
            rf_we    <= 1'b1;
            rf_waddr <= head.rd;
            rf_wdata <= head.data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    always_comb begin
        busy = '0;
        if (tag_q.valid && (tag_q.rd != '0)) busy[tag_q.rd] = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) busy[entry_rd[i]] = 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus random traffic, all checked
// against a queue-based model of the writeback behaviour.
module tb_wb_stage;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic [1:0]  issue_sel;
    logic [4:0]  issue_rd;
    logic [31:0] rslt1;
    logic [31:0] rslt3;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy;
    logic        stall;
    logic        ovf_err;

    wb_stage #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_sel   (issue_sel),
        .issue_rd    (issue_rd),
        .rslt1       (rslt1),
        .rslt3       (rslt3),
        .lsu_valid   (lsu_valid),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .busy        (busy),
        .stall       (stall),
        .ovf_err     (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ment_t;

    ment_t       m_q[$];
    bit          m_tag_v;
    logic [1:0]  m_tag_sel;
    logic [4:0]  m_tag_rd;
    bit          m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    bit          m_ovf;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] b = '0;
        if (m_tag_v && m_tag_rd != 0) b[m_tag_rd] = 1'b1;
        foreach (m_q[i]) b[m_q[i].rd] = 1'b1;
        return b;
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_tag_v = 0; m_tag_sel = '0; m_tag_rd = '0;
        m_we = 0; m_addr = '0; m_data = '0; m_ovf = 0;
    endtask

    // One clock: called just after an edge, drives inputs, checks the
    // combinational outputs, advances the model, then checks registered ones.
    task automatic cyc(input bit iv, input logic [1:0] sel, input logic [4:0] rd,
                       input logic [31:0] r1, input logic [31:0] r3,
                       input bit lv, input logic [4:0] lrd, input logic [31:0] ld);
        bit    st;
        ment_t e;
        issue_valid = iv; issue_sel = sel; issue_rd = rd;
        rslt1 = r1; rslt3 = r3;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        #1;
        st = (m_q.size() + int'(m_tag_v)) >= DEPTH - 1;
        chk("stall", stall, st);
        chk("busy", busy, model_busy());
        if (lv) begin
            m_we = 1; m_addr = lrd; m_data = ld;
        end else if (m_q.size() > 0) begin
            e = m_q.pop_front();
            m_we = 1; m_addr = e.rd; m_data = e.data;
        end else begin
            m_we = 0;
        end
        if (m_tag_v && m_tag_rd != 0) begin
            e.rd = m_tag_rd;
            e.data = (m_tag_sel == 2'd1) ? r3 : r1;
            m_q.push_back(e);
        end
        if (iv && st) m_ovf = 1;
        m_tag_v = iv && !st; m_tag_sel = sel; m_tag_rd = rd;
        @(posedge clk); #1;
        chk("rf_we", rf_we, m_we);
        chk("rf_waddr", rf_waddr, m_addr);
        chk("rf_wdata", rf_wdata, m_data);
        chk("ovf_err", ovf_err, m_ovf);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 2'd0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 32'h0);
    endtask

    task automatic do_reset();
        issue_valid = 0; lsu_valid = 0;
        rst_n = 0;
        #2;
        chk("rst_we", rf_we, 1'b0);
        chk("rst_waddr", rf_waddr, 5'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk("rst_ovf", ovf_err, 1'b0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_stall", stall, 1'b0);
        model_clear();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 0;
        issue_valid = 0; issue_sel = '0; issue_rd = '0;
        rslt1 = '0; rslt3 = '0;
        lsu_valid = 0; lsu_rd = '0; lsu_data = '0;
        model_clear();
        #1;
        do_reset();

        // shifter result to r5, busy across the pipe
        cyc(1, 2'd1, 5'd5, 32'h0, 32'h0, 0, 5'd0, 32'h0);
        chk("t1_busy5_e0", busy[5], 1'b1);
        cyc(0, 2'd0, 5'd0, 32'h1234, 32'h10, 0, 5'd0, 32'h0);
        chk("t1_busy5_e1", busy[5], 1'b1);
        cyc(0, 2'd0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 32'h0);
        chk("t1_we", rf_we, 1'b1);
        chk("t1_waddr", rf_waddr, 5'd5);
        chk("t1_wdata", rf_wdata, 32'h10);
        chk("t1_busy5_e2", busy[5], 1'b0);
        idle(1);

        // rd=0 is never buffered
        cyc(1, 2'd0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 32'h0);
        cyc(0, 2'd0, 5'd0, 32'hFFFF, 32'h0, 0, 5'd0, 32'h0);
        cyc(0, 2'd0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 32'h0);
        chk("t2_we", rf_we, 1'b0);
        chk("t2_busy", busy, 32'd0);

        // load to same rd wins first, buffered ALU value lands last
        cyc(1, 2'd0, 5'd3, 32'h0, 32'h0, 0, 5'd0, 32'h0);
        cyc(0, 2'd0, 5'd0, 32'hA, 32'h0, 0, 5'd0, 32'h0);
        cyc(0, 2'd0, 5'd0, 32'h0, 32'h0, 1, 5'd3, 32'hB);
        chk("t3_wdata_lsu", rf_wdata, 32'hB);
        cyc(0, 2'd0, 5'd0, 32'h0, 32'h0, 1, 5'd3, 32'hB);
        cyc(0, 2'd0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 32'h0);
        chk("t3_wdata_alu", rf_wdata, 32'hA);
        chk("t3_waddr", rf_waddr, 5'd3);
        idle(1);
        chk("t3_empty", busy, 32'd0);

        // two shifts to r7
        cyc(1, 2'd1, 5'd7, 32'h0, 32'h0, 0, 5'd0, 32'h0);
        cyc(1, 2'd1, 5'd7, 32'h0, 32'h1, 0, 5'd0, 32'h0);
        cyc(0, 2'd0, 5'd0, 32'h0, 32'h2, 0, 5'd0, 32'h0);
        idle(3);

        // fill under a held load, overflow, then drain in order
        for (int i = 1; i <= 4; i++)
            cyc(1, 2'd0, 5'(i), 32'h100 + i, 32'h0, 1, 5'd20, 32'hDEAD);
        cyc(0, 2'd0, 5'd0, 32'h105, 32'h0, 1, 5'd20, 32'hDEAD);
        chk("t4_ovf", ovf_err, 1'b1);
        idle(5);

        // reset with entries and a live tag in flight
        for (int i = 0; i < 3; i++)
            cyc(1, 2'd0, 5'(9 + i), 32'h200 + i, 32'h0, 1, 5'd21, 32'hBEEF);
        do_reset();
        idle(4);
        chk("t6_no_write", rf_we, 1'b0);

        for (int n = 0; n < 600; n++) begin
            if (n % 150 == 149) do_reset();
            cyc(($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
                $urandom, $urandom,
                ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)), $urandom);
        end
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
